// File: rtl/rotor_rewind_if.sv
// Request/busy/done handshake between the control FSM and the reverse
// rotor stepper.
//   rewind_req   : request level; a 0->1 transition starts a rewind
//   rewind_count : keystrokes to undo, captured with the request edge
//   busy         : rewind in progress
//   done         : one-cycle completion pulse
interface rotor_rewind_if #(
    parameter int CNT_W = 8
);
    logic             rewind_req;
    logic [CNT_W-1:0] rewind_count;
    logic             busy;
    logic             done;

    modport master (
        output rewind_req,
        output rewind_count,
        input  busy,
        input  done
    );

    modport slave (
        input  rewind_req,
        input  rewind_count,
        output busy,
        output done
    );
endinterface

// File: rtl/rotor_rewind.sv
// Reverse-direction rotor stepper: walks rotor1..rotor3 backwards by a
// requested number of keystrokes, undoing forward stepping.
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   bus            : request/busy/done handshake (slave side)
//   rotor_type_2/3 : wheel types of middle/right rotor, held while busy
//   rotor_start_*  : positions loaded on reset
//   rotor1..3      : registered rotor positions (left, middle, right)
module rotor_rewind #(
    parameter int NUM_POS = 26,
    parameter int CNT_W   = 8
) (
    input  logic        clock,
    input  logic        reset,
    rotor_rewind_if.slave bus,
    input  logic [2:0]  rotor_type_2,
    input  logic [2:0]  rotor_type_3,
    input  logic [4:0]  rotor_start_1,
    input  logic [4:0]  rotor_start_2,
    input  logic [4:0]  rotor_start_3,
    output logic [4:0]  rotor1,
    output logic [4:0]  rotor2,
    output logic [4:0]  rotor3
);
    typedef enum logic [2:0] {IDLE, S3, S2, S1, NEXT, FIN} state_t;

    localparam logic [4:0] MAX_POS = 5'(NUM_POS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       rotor1_q, rotor1_d;
    logic [4:0]       rotor2_q, rotor2_d;
    logic [4:0]       rotor3_q, rotor3_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             prev_req_q;
    logic             req_rise;

    // A rotor drags its left neighbour back when it leaves this position
    // going backwards, mirroring the forward "arrive at carry" rule.
    function automatic logic is_carry(input logic [2:0] t, input logic [4:0] p);
        case (t)
            3'd0:    return p == 5'd17;
            3'd1:    return p == 5'd5;
            3'd2:    return p == 5'd22;
            3'd3:    return p == 5'd10;
            3'd4:    return p == 5'd0;
            default: return (p == 5'd0) || (p == 5'd13);
        endcase
    endfunction

    // Wrap explicitly at NUM_POS rather than relying on 5-bit rollover.
    function automatic logic [4:0] dec(input logic [4:0] p);
        return (p == 5'd0) ? MAX_POS : p - 5'd1;
    endfunction

    assign req_rise = bus.rewind_req && !prev_req_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rotor1_d = rotor1_q;
        rotor2_d = rotor2_q;
        rotor3_d = rotor3_q;
        case (state_q)
            IDLE: begin
                // Zero-count requests are dropped without any handshake.
                if (req_rise && bus.rewind_count != '0) begin
                    cnt_d   = bus.rewind_count;
                    state_d = S3;
                end
            end
            S3: begin
                rotor3_d = dec(rotor3_q);
                state_d  = is_carry(rotor_type_3, rotor3_q) ? S2 : NEXT;
            end
            S2: begin
                rotor2_d = dec(rotor2_q);
                state_d  = is_carry(rotor_type_2, rotor2_q) ? S1 : NEXT;
            end
            S1: begin
                rotor1_d = dec(rotor1_q);
                state_d  = NEXT;
            end
            NEXT: begin
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == CNT_W'(1)) ? FIN : S3;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Outputs are registered from the next state so they line up with it.
        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rotor1_q   <= rotor_start_1;
            rotor2_q   <= rotor_start_2;
            rotor3_q   <= rotor_start_3;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            prev_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rotor1_q   <= rotor1_d;
            rotor2_q   <= rotor2_d;
            rotor3_q   <= rotor3_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            prev_req_q <= bus.rewind_req;
        end
    end

    assign rotor1   = rotor1_q;
    assign rotor2   = rotor2_q;
    assign rotor3   = rotor3_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_rotor_rewind.sv
module tb_rotor_rewind;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] rotor_type_2 = '0, rotor_type_3 = '0;
    logic [4:0] rotor_start_1 = '0, rotor_start_2 = '0, rotor_start_3 = '0;
    logic [4:0] rotor1, rotor2, rotor3;

    rotor_rewind_if #(.CNT_W(8)) rif ();

    rotor_rewind #(.NUM_POS(26), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .bus(rif.slave),
        .rotor_type_2(rotor_type_2), .rotor_type_3(rotor_type_3),
        .rotor_start_1(rotor_start_1), .rotor_start_2(rotor_start_2),
        .rotor_start_3(rotor_start_3),
        .rotor1(rotor1), .rotor2(rotor2), .rotor3(rotor3)
    );

    always #5 clock = ~clock;

    typedef struct {
        int s1, s2, s3;
        int t2, t3;
        int cnt;
        int e1, e2, e3;
        int ebusy;
    } vec_t;

    typedef struct {
        int r1, r2, r3, busy_cycles;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Reference: walk keystrokes one at a time with the inverse cascade.
    function automatic bit mcarry(input int t, input int p);
        if (t == 0) return p == 17;
        if (t == 1) return p == 5;
        if (t == 2) return p == 22;
        if (t == 3) return p == 10;
        if (t == 4) return p == 0;
        return p == 0 || p == 13;
    endfunction

    function automatic exp_t model(input int s1, s2, s3, t2, t3, cnt);
        exp_t e;
        e.r1 = s1; e.r2 = s2; e.r3 = s3; e.busy_cycles = 1;
        for (int k = 0; k < cnt; k++) begin
            bit c3, c2;
            c3 = mcarry(t3, e.r3);
            e.r3 = (e.r3 + 25) % 26;
            e.busy_cycles += 2;
            if (c3) begin
                c2 = mcarry(t2, e.r2);
                e.r2 = (e.r2 + 25) % 26;
                e.busy_cycles += 1;
                if (c2) begin
                    e.r1 = (e.r1 + 25) % 26;
                    e.busy_cycles += 1;
                end
            end
        end
        return e;
    endfunction

    task automatic do_reset(input int s1, s2, s3);
        @(negedge clock);
        rif.rewind_req = 1'b0;
        rotor_start_1 = 5'(s1); rotor_start_2 = 5'(s2); rotor_start_3 = 5'(s3);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Issue one request; optionally raise a second edge mid-run.
    task automatic run(input string name, input int cnt, input bit glitch);
        int   busy_cnt, done_cnt;
        bit   seen;
        exp_t e;
        busy_cnt = 0; done_cnt = 0; seen = 0;
        @(negedge clock);
        rif.rewind_count = 8'(cnt);
        rif.rewind_req   = 1'b1;
        for (int c = 0; c < 3000 && !seen; c++) begin
            @(negedge clock);
            if (c == 0) rif.rewind_req = 1'b0;
            if (glitch && c == 5) rif.rewind_req = 1'b1;
            if (glitch && c == 7) rif.rewind_req = 1'b0;
            if (rif.busy) busy_cnt++;
            if (rif.done) begin done_cnt++; seen = 1; end
        end
        check({name, " done seen"}, int'(seen), 1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (rif.done) done_cnt++;
            if (rif.busy) busy_cnt++;
        end
        if (sb.size() == 0) begin
            check({name, " scoreboard entry"}, 0, 1);
        end else begin
            e = sb.pop_front();
            check({name, " rotor1"}, int'(rotor1), e.r1);
            check({name, " rotor2"}, int'(rotor2), e.r2);
            check({name, " rotor3"}, int'(rotor3), e.r3);
            check({name, " busy cycles"}, busy_cnt, e.busy_cycles);
        end
        check({name, " done pulses"}, done_cnt, 1);
    endtask

    task automatic vec_run(input string name, input vec_t v, input bit glitch);
        exp_t e;
        do_reset(v.s1, v.s2, v.s3);
        rotor_type_2 = 3'(v.t2);
        rotor_type_3 = 3'(v.t3);
        e.r1 = v.e1; e.r2 = v.e2; e.r3 = v.e3; e.busy_cycles = v.ebusy;
        sb.push_back(e);
        run(name, v.cnt, glitch);
    endtask

    vec_t vecs[6];

    initial begin
        rif.rewind_req   = 1'b0;
        rif.rewind_count = '0;
        vecs[0] = '{s1:0, s2:0,  s3:5,  t2:0, t3:0, cnt:1,  e1:0,  e2:0,  e3:4,  ebusy:3};
        vecs[1] = '{s1:4, s2:9,  s3:0,  t2:0, t3:0, cnt:1,  e1:4,  e2:9,  e3:25, ebusy:3};
        vecs[2] = '{s1:0, s2:5,  s3:17, t2:1, t3:0, cnt:1,  e1:25, e2:4,  e3:16, ebusy:5};
        vecs[3] = '{s1:0, s2:0,  s3:0,  t2:0, t3:0, cnt:30, e1:0,  e2:25, e3:22, ebusy:62};
        vecs[4] = '{s1:3, s2:13, s3:0,  t2:5, t3:5, cnt:2,  e1:2,  e2:12, e3:24, ebusy:7};
        vecs[5] = '{s1:1, s2:10, s3:1,  t2:3, t3:4, cnt:2,  e1:0,  e2:9,  e3:25, ebusy:7};

        // Reset state
        do_reset(3, 7, 11);
        check("reset rotor1", int'(rotor1), 3);
        check("reset rotor2", int'(rotor2), 7);
        check("reset rotor3", int'(rotor3), 11);
        check("reset busy", int'(rif.busy), 0);
        check("reset done", int'(rif.done), 0);

        // Zero count: edge ignored, nothing moves
        begin
            int seen_busy, seen_done;
            seen_busy = 0; seen_done = 0;
            @(negedge clock);
            rif.rewind_count = 8'd0;
            rif.rewind_req   = 1'b1;
            for (int c = 0; c < 10; c++) begin
                @(negedge clock);
                rif.rewind_req = 1'b0;
                seen_busy += int'(rif.busy);
                seen_done += int'(rif.done);
            end
            check("zero count busy", seen_busy, 0);
            check("zero count done", seen_done, 0);
            check("zero count rotor3", int'(rotor3), 11);
        end

        // Table vectors; the 30-step one also gets a mid-run second edge
        foreach (vecs[i]) vec_run($sformatf("vec%0d", i), vecs[i], i == 3);

        // Random vectors checked against the reference model
        for (int i = 0; i < 6; i++) begin
            vec_t v;
            exp_t e;
            v.s1 = $urandom_range(0, 25); v.s2 = $urandom_range(0, 25);
            v.s3 = $urandom_range(0, 25);
            v.t2 = $urandom_range(0, 7);  v.t3 = $urandom_range(0, 7);
            v.cnt = $urandom_range(1, 60);
            e = model(v.s1, v.s2, v.s3, v.t2, v.t3, v.cnt);
            v.e1 = e.r1; v.e2 = e.r2; v.e3 = e.r3; v.ebusy = e.busy_cycles;
            vec_run($sformatf("rnd%0d", i), v, 1'b0);
        end

        // Reset in the 4th busy cycle abandons the operation
        begin
            int busy_cnt, done_cnt;
            exp_t e;
            busy_cnt = 0; done_cnt = 0;
            do_reset(3, 7, 11);
            rotor_type_2 = 3'd0; rotor_type_3 = 3'd0;
            @(negedge clock);
            rif.rewind_count = 8'd10;
            rif.rewind_req   = 1'b1;
            for (int c = 0; c < 50 && busy_cnt < 4; c++) begin
                @(negedge clock);
                rif.rewind_req = 1'b0;
                if (rif.busy) busy_cnt++;
            end
            check("midreset reached busy4", busy_cnt, 4);
            reset = 1'b1;
            @(negedge clock);
            reset = 1'b0;
            check("midreset rotor1", int'(rotor1), 3);
            check("midreset rotor2", int'(rotor2), 7);
            check("midreset rotor3", int'(rotor3), 11);
            check("midreset busy", int'(rif.busy), 0);
            for (int c = 0; c < 30; c++) begin
                @(negedge clock);
                done_cnt += int'(rif.done) + int'(rif.busy);
            end
            check("midreset no done/busy after", done_cnt, 0);
            e.r1 = 3; e.r2 = 7; e.r3 = 10; e.busy_cycles = 3;
            sb.push_back(e);
            run("post reset", 1, 1'b0);
        end

        check("scoreboard drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
